line_clear_engine: RTL and testbench

LINE_CLEAR_ENGINE -- requirements
Module: line_clear_engine

---
 rtl/tetris_pkg.sv | 31 +++
 rtl/lce_hole_lfsr.sv | 26 ++
 rtl/line_clear_engine.sv | 149 ++++++++++++++
 tb/tb_line_clear_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants, FSM state encoding and the row-drop helper for line_clear_engine.
package tetris_pkg;

  localparam int ROWS  = 10;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;

  localparam logic [3:0] LFSR_SEED = 4'b1001;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SCAN    = 3'd2,
    SHIFT   = 3'd3,
    GARBAGE = 3'd4,
    DONE    = 3'd5
  } state_e;

  // Rows 1..ptr take the contents of the row above them; row 0 (top) is emptied.
  function automatic logic [CELLS-1:0] clear_row(input logic [CELLS-1:0] grid,
                                                 input logic [3:0]       ptr);
    logic [CELLS-1:0] res;
    res = grid;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(ptr)) res[r*COLS +: COLS] = grid[(r-1)*COLS +: COLS];
    end
    res[COLS-1:0] = '0;
    return res;
  endfunction

endpackage

// File: rtl/lce_hole_lfsr.sv
// Free-running 4-bit LFSR (x^4+x^3+1) giving the garbage-row hole column, 0..9.
// Only built when LINE_CLEAR_GARBAGE_EN is defined.
`ifdef LINE_CLEAR_GARBAGE_EN
module lce_hole_lfsr
  import tetris_pkg::*;
(
  input  logic       clk_40M,
  input  logic       rst,
  output logic [3:0] hole
);

  logic [3:0] lfsr_q;
  logic [3:0] lfsr_d;

  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  // The LFSR never reaches 0 and tops out at 15, so a single subtract folds it into 0..9.
  assign hole = (lfsr_q >= 4'd10) ? lfsr_q - 4'd10 : lfsr_q;

endmodule
`endif

// File: rtl/line_clear_engine.sv
// Tetris line-clear engine: scans a 10x10 grid bottom-up, drops cleared rows, then
// optionally pushes opponent garbage rows (LINE_CLEAR_GARBAGE_EN).
module line_clear_engine
  import tetris_pkg::*;
(
  input  logic             clk_40M,
  input  logic             rst,
  input  logic             start,
  input  logic [CELLS-1:0] table_in,
  input  logic             add_line,
  output logic [CELLS-1:0] table_out,
  output logic             busy,
  output logic             done,
  output logic [2:0]       lines_cleared,
  output logic             send_line,
  output logic             overflow
);

  state_e           state_q;
  logic [CELLS-1:0] grid_q;
  logic [CELLS-1:0] table_out_q;
  logic [3:0]       ptr_q;
  logic [2:0]       clr_q;
  logic [2:0]       lines_q;
  logic             busy_q;
  logic             done_q;
  logic             send_q;

  logic [COLS-1:0]  scan_row;
  logic             row_full;
  logic             garbage_go;

  assign scan_row = grid_q[int'(ptr_q)*COLS +: COLS];
  assign row_full = &scan_row;

`ifdef LINE_CLEAR_GARBAGE_EN
  logic [1:0]       pending_q;
  logic [1:0]       pending_d;
  logic             overflow_q;
  logic [3:0]       hole;
  logic             garb_step;
  logic [COLS-1:0]  garb_row;
  logic [CELLS-1:0] garb_grid;

  lce_hole_lfsr u_hole (
    .clk_40M (clk_40M),
    .rst     (rst),
    .hole    (hole)
  );

  assign garb_step  = (state_q == GARBAGE);
  assign garbage_go = (pending_q != 2'd0);
  assign garb_row   = ~({{(COLS-1){1'b0}}, 1'b1} << hole);
  assign garb_grid  = {garb_row, grid_q[CELLS-1:COLS]};

  // NOTE: pending_d gets its default before any branch so no latch is inferred.
  always_comb begin
    pending_d = pending_q;
    if (add_line && !garb_step) begin
      if (pending_q != 2'd3) pending_d = pending_q + 2'd1;
    end else if (garb_step && !add_line) begin
      pending_d = pending_q - 2'd1;
    end
  end

  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      pending_q  <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (garb_step && (grid_q[COLS-1:0] != '0)) overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  logic add_line_unused;

  assign add_line_unused = add_line;
  assign garbage_go      = 1'b0;
  assign overflow        = 1'b0;
`endif

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_40M or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grid_q      <= '0;
      table_out_q <= '0;
      ptr_q       <= '0;
      clr_q       <= '0;
      lines_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      send_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      send_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          grid_q  <= table_in;
          ptr_q   <= 4'(ROWS - 1);
          clr_q   <= '0;
          state_q <= SCAN;
        end
        SCAN: begin
          if (row_full)            state_q <= SHIFT;
          else if (ptr_q != 4'd0)  ptr_q   <= ptr_q - 4'd1;
          else                     state_q <= garbage_go ? GARBAGE : DONE;
        end
        // The pointer stays put so the row that just dropped into place is rescanned.
        SHIFT: begin
          grid_q <= clear_row(grid_q, ptr_q);
          if (clr_q != 3'd4) clr_q <= clr_q + 3'd1;
          state_q <= SCAN;
        end
`ifdef LINE_CLEAR_GARBAGE_EN
        GARBAGE: begin
          grid_q <= garb_grid;
          if (pending_d == 2'd0) state_q <= DONE;
        end
`endif
        DONE: begin
          table_out_q <= grid_q;
          lines_q     <= clr_q;
          done_q      <= 1'b1;
          send_q      <= (clr_q >= 3'd2);
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign table_out     = table_out_q;
  assign lines_cleared = lines_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign send_line     = send_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench for line_clear_engine: a row-compaction model predicts each result,
// a negedge monitor checks it when done pulses. Follows LINE_CLEAR_GARBAGE_EN like the RTL.
module tb_line_clear_engine;

  localparam int ROWS  = 10;
  localparam int COLS  = 10;
  localparam int CELLS = ROWS * COLS;
`ifdef LINE_CLEAR_GARBAGE_EN
  localparam bit GARB_EN = 1'b1;
`else
  localparam bit GARB_EN = 1'b0;
`endif

  typedef struct {
    logic [CELLS-1:0] tbl;
    int               lines;
    bit               send;
    bit               ovf;
    int               lat;
    int               start_edge;
  } exp_t;

  logic             clk_40M = 1'b0;
  logic             rst;
  logic             start;
  logic [CELLS-1:0] table_in;
  logic             add_line;
  logic [CELLS-1:0] table_out;
  logic             busy;
  logic             done;
  logic [2:0]       lines_cleared;
  logic             send_line;
  logic             overflow;

  exp_t             sb_q[$];
  int               n_checks  = 0;
  int               n_errors  = 0;
  int               edge_cnt  = 0;
  int               m_pending = 0;
  bit               m_overflow = 1'b0;
  logic [CELLS-1:0] m_out = '0;

  always #5 clk_40M = ~clk_40M;

  line_clear_engine dut (
    .clk_40M       (clk_40M),
    .rst           (rst),
    .start         (start),
    .table_in      (table_in),
    .add_line      (add_line),
    .table_out     (table_out),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .send_line     (send_line),
    .overflow      (overflow)
  );

  // Counts rising edges since reset release; the value seen at an edge is that edge's index.
  always @(posedge clk_40M or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_40M);
    #1;
  endtask

  // Full rows vanish; the remaining rows keep their order and settle at the bottom.
  function automatic void model_clear(input logic [CELLS-1:0] g, output logic [CELLS-1:0] res,
                                      output int c);
    int dst;
    dst = ROWS - 1;
    res = '0;
    c   = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (g[r*COLS +: COLS] == {COLS{1'b1}}) c++;
      else begin
        res[dst*COLS +: COLS] = g[r*COLS +: COLS];
        dst--;
      end
    end
  endfunction

  // Hole column at edge k: seed 1001 advanced k times by x^4+x^3+1 (period 15), modulo 10.
  function automatic int hole_at(input int k);
    logic [3:0] s;
    s = 4'b1001;
    for (int i = 0; i < (k % 15); i++) s = {s[2:0], s[3] ^ s[2]};
    return int'(s) % 10;
  endfunction

  function automatic logic [CELLS-1:0] rand_grid();
    logic [CELLS-1:0] g;
    int               k;
    for (int r = 0; r < ROWS; r++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      g[r*COLS +: COLS] = '1;
      else if (k < 5) g[r*COLS +: COLS] = '0;
      else            g[r*COLS +: COLS] = 10'($urandom);
    end
    return g;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_table_out"}, table_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_send_line"}, send_line, 0);
    check({tag, "_lines_cleared"}, lines_cleared, 0);
    check({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic pulse_add();
    add_line = 1'b1;
    tick();
    add_line = 1'b0;
    if (GARB_EN && m_pending < 3) m_pending++;
  endtask

  // Predicts the full outcome of one operation, queues it, and fires start.
  task automatic issue_op(input logic [CELLS-1:0] grid, input bit add_flag, output int add_edge);
    exp_t             e;
    logic [CELLS-1:0] res;
    logic [COLS-1:0]  grow;
    int               c, g, p, e0;
    model_clear(grid, res, c);
    e0       = edge_cnt;
    p        = GARB_EN ? m_pending : 0;
    g        = (add_flag && p > 0) ? p + 1 : p;
    add_edge = e0 + 12 + 2 * c;
    for (int j = 0; j < g; j++) begin
      grow = '1;
      grow[hole_at(add_edge + j)] = 1'b0;
      if (res[COLS-1:0] != '0) m_overflow = 1'b1;
      res = {grow, res[CELLS-1:COLS]};
    end
    m_pending    = (GARB_EN && add_flag && p == 0) ? 1 : 0;
    e.tbl        = res;
    e.lines      = (c > 4) ? 4 : c;
    e.send       = (c >= 2);
    e.ovf        = m_overflow;
    e.lat        = 12 + 2 * c + g;
    e.start_edge = e0;
    sb_q.push_back(e);
    table_in = grid;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic finish_op(input bit add_flag, input int add_edge);
    if (add_flag) begin
      for (int i = 0; i < 100 && edge_cnt < add_edge; i++) tick();
      add_line = 1'b1;
      tick();
      add_line = 1'b0;
    end
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick();
    check("done_seen", sb_q.size(), 0);
    check("busy_idle", busy, 0);
    sb_q.delete();
    tick();
  endtask

  task automatic run_op(input logic [CELLS-1:0] grid, input bit add_flag, input bit mid_start);
    int add_edge;
    issue_op(grid, add_flag, add_edge);
    if (mid_start) begin
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    finish_op(add_flag, add_edge);
  endtask

  task automatic sample_outputs();
    exp_t e;
    if (rst) return;
    if (done) begin
      check("done_expected", 128'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("table_out", table_out, e.tbl);
        check("lines_cleared", lines_cleared, e.lines);
        check("send_line", send_line, e.send);
        check("overflow", overflow, e.ovf);
        check("latency", edge_cnt - 1 - e.start_edge, e.lat);
        check("busy_at_done", busy, 0);
        m_out = e.tbl;
      end
    end else begin
      check("send_idle", send_line, 0);
      check("table_hold", table_out, m_out);
    end
  endtask

  always @(negedge clk_40M) sample_outputs();

  initial begin
    logic [CELLS-1:0] g;
    int               add_edge;
    rst      = 1'b1;
    start    = 1'b0;
    add_line = 1'b0;
    table_in = '0;
    #17;
    check_reset_outputs("por");
    tick();
    rst = 1'b0;
    tick();

    run_op('0, 1'b0, 1'b0);
    g = '0; g[90 +: 10] = '1; g[85] = 1'b1;
    run_op(g, 1'b0, 1'b0);
    g = '0; g[60 +: 40] = '1;
    run_op(g, 1'b0, 1'b1);
    g = '0; g[80 +: 10] = '1; g[60 +: 10] = '1; g[70 +: 5] = '1;
    run_op(g, 1'b0, 1'b0);
    g = '1;
    run_op(g, 1'b0, 1'b0);
    g = '0; g[0 +: 10] = '1; g[42] = 1'b1;
    run_op(g, 1'b0, 1'b0);

`ifdef LINE_CLEAR_GARBAGE_EN
    repeat (4) pulse_add();
    run_op('0, 1'b0, 1'b0);
    pulse_add();
    g = '0; g[3] = 1'b1;
    run_op(g, 1'b0, 1'b0);
    pulse_add();
    run_op('0, 1'b1, 1'b0);
`endif

    // Abort mid-scan: no done may follow, and the next operation must run normally.
    g = '0; g[80 +: 10] = '1; g[11] = 1'b1;
    issue_op(g, 1'b0, add_edge);
    repeat (4) tick();
    rst = 1'b1;
    sb_q.delete();
    m_out      = '0;
    m_pending  = 0;
    m_overflow = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    tick();
    rst = 1'b0;
    repeat (20) tick();
    run_op(g, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 4)) pulse_add();
      run_op(rand_grid(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
